// File: rtl/virtio_pkg.sv
// Shared constants for the virtio shell blocks: FSM encodings, used-ring layout
// offsets and AXI response codes.
package virtio_pkg;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_EL_AW = 4'd1;
  localparam logic [3:0] S_EL_W0 = 4'd2;
  localparam logic [3:0] S_EL_W1 = 4'd3;
  localparam logic [3:0] S_EL_B  = 4'd4;
  localparam logic [3:0] S_IX_AW = 4'd5;
  localparam logic [3:0] S_IX_W  = 4'd6;
  localparam logic [3:0] S_IX_B  = 4'd7;
  localparam logic [3:0] S_IRQ   = 4'd8;

  localparam int unsigned USED_IDX_OFF    = 2;
  localparam int unsigned USED_RING_OFF   = 4;
  localparam int unsigned USED_ELEM_BYTES = 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Byte strobe for a 16-bit field at the given byte offset within a 32-bit word.
  function automatic logic [3:0] half_strb(input int unsigned off);
    return (off[1]) ? 4'b1100 : 4'b0011;
  endfunction

endpackage

// File: rtl/virtio_used_ring_writer.sv
// Virtqueue completion engine: writes one used-ring element plus used.idx over
// AXI4 per accepted completion, then raises a one-cycle per-queue interrupt.
module virtio_used_ring_writer
  import virtio_pkg::*;
#(
  parameter int NUM_QUEUES = 3,
  parameter int ADDR_W     = 64,
  parameter int IDX_W      = 16,
  localparam int QID_W     = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
  input  logic                         clk,
  input  logic                         csr_rst,
  input  logic                         cpl_valid,
  output logic                         cpl_ready,
  input  logic [QID_W-1:0]             cpl_qid,
  input  logic [31:0]                  cpl_id,
  input  logic [31:0]                  cpl_len,
  input  logic [NUM_QUEUES-1:0]        queue_enable,
  input  logic [NUM_QUEUES*IDX_W-1:0]  queue_size,
  input  logic [NUM_QUEUES*ADDR_W-1:0] queue_used_addr,
  output logic                         m_awvalid,
  input  logic                         m_awready,
  output logic [ADDR_W-1:0]            m_awaddr,
  output logic [7:0]                   m_awlen,
  output logic [2:0]                   m_awsize,
  output logic                         m_wvalid,
  input  logic                         m_wready,
  output logic [31:0]                  m_wdata,
  output logic [3:0]                   m_wstrb,
  output logic                         m_wlast,
  input  logic                         m_bvalid,
  output logic                         m_bready,
  input  logic [1:0]                   m_bresp,
  output logic [NUM_QUEUES*IDX_W-1:0]  used_idx,
  output logic [NUM_QUEUES-1:0]        irq_pulse,
  output logic [NUM_QUEUES-1:0]        err_sticky
);

  logic [3:0]                  state;
  logic [QID_W-1:0]            qid_r;
  logic [31:0]                 id_r;
  logic [31:0]                 len_r;
  logic [NUM_QUEUES*IDX_W-1:0] used_idx_r;
  logic [NUM_QUEUES-1:0]       err_r;

  logic                  in_ok;
  logic [NUM_QUEUES-1:0] in_onehot;
  logic [NUM_QUEUES-1:0] cur_onehot;
  logic [IDX_W-1:0]      cur_size;
  logic [IDX_W-1:0]      cur_idx;
  logic [ADDR_W-1:0]     cur_base;
  logic [IDX_W-1:0]      slot;
  logic [IDX_W-1:0]      next_idx;
  logic [ADDR_W-1:0]     elem_addr;
  logic [ADDR_W-1:0]     idx_addr;

  // Out-of-range qids match no queue: they are dropped without touching any error bit.
  always_comb begin
    in_ok      = 1'b0;
    in_onehot  = '0;
    cur_onehot = '0;
    cur_size   = '0;
    cur_idx    = '0;
    cur_base   = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (cpl_qid == QID_W'(i)) begin
        in_onehot[i] = 1'b1;
        in_ok        = queue_enable[i] && (queue_size[i*IDX_W +: IDX_W] != '0);
      end
      if (qid_r == QID_W'(i)) begin
        cur_onehot[i] = 1'b1;
        cur_size      = queue_size[i*IDX_W +: IDX_W];
        cur_idx       = used_idx_r[i*IDX_W +: IDX_W];
        cur_base      = queue_used_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign slot      = cur_idx & (cur_size - IDX_W'(1));
  assign next_idx  = cur_idx + IDX_W'(1);
  assign elem_addr = cur_base + ADDR_W'(USED_RING_OFF) + ADDR_W'(slot) * ADDR_W'(USED_ELEM_BYTES);
  assign idx_addr  = cur_base + (ADDR_W'(USED_IDX_OFF) & ~ADDR_W'(3));

  always_comb begin
    m_awvalid = 1'b0;
    m_awaddr  = '0;
    m_awlen   = 8'd0;
    m_wvalid  = 1'b0;
    m_wdata   = 32'd0;
    m_wstrb   = 4'h0;
    m_wlast   = 1'b0;
    m_bready  = 1'b0;
    case (state)
      S_EL_AW: begin
        m_awvalid = 1'b1;
        m_awaddr  = elem_addr;
        m_awlen   = 8'd1;
      end
      S_EL_W0: begin
        m_wvalid = 1'b1;
        m_wdata  = id_r;
        m_wstrb  = 4'hF;
      end
      S_EL_W1: begin
        m_wvalid = 1'b1;
        m_wdata  = len_r;
        m_wstrb  = 4'hF;
        m_wlast  = 1'b1;
      end
      S_IX_AW: begin
        m_awvalid = 1'b1;
        m_awaddr  = idx_addr;
      end
      S_IX_W: begin
        m_wvalid = 1'b1;
        m_wdata  = {next_idx, 16'h0000};
        m_wstrb  = half_strb(USED_IDX_OFF);
        m_wlast  = 1'b1;
      end
      S_EL_B, S_IX_B: m_bready = 1'b1;
      default: ;
    endcase
  end

  assign m_awsize   = 3'b010;
  assign cpl_ready  = (state == S_IDLE) && !csr_rst;
  assign irq_pulse  = (state == S_IRQ) ? cur_onehot : '0;
  assign used_idx   = used_idx_r;
  assign err_sticky = err_r;

  always_ff @(posedge clk) begin
    if (csr_rst) begin
      state      <= S_IDLE;
      qid_r      <= '0;
      id_r       <= '0;
      len_r      <= '0;
      used_idx_r <= '0;
      err_r      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpl_valid) begin
            qid_r <= cpl_qid;
            id_r  <= cpl_id;
            len_r <= cpl_len;
            if (in_ok) state <= S_EL_AW;
            else       err_r <= err_r | in_onehot;
          end
        end
        S_EL_AW: if (m_awready) state <= S_EL_W0;
        S_EL_W0: if (m_wready)  state <= S_EL_W1;
        S_EL_W1: if (m_wready)  state <= S_EL_B;
        S_EL_B: begin
          if (m_bvalid) begin
            if (m_bresp != AXI_RESP_OKAY) begin
              err_r <= err_r | cur_onehot;
              state <= S_IDLE;
            end else begin
              state <= S_IX_AW;
            end
          end
        end
        S_IX_AW: if (m_awready) state <= S_IX_W;
        S_IX_W:  if (m_wready)  state <= S_IX_B;
        // A failed index write still commits: the element is already in host memory.
        S_IX_B: begin
          if (m_bvalid) begin
            if (m_bresp != AXI_RESP_OKAY) err_r <= err_r | cur_onehot;
            for (int i = 0; i < NUM_QUEUES; i++) begin
              if (qid_r == QID_W'(i)) used_idx_r[i*IDX_W +: IDX_W] <= next_idx;
            end
            state <= S_IRQ;
          end
        end
        S_IRQ:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
